// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, default counter width and delay-counter sizing.
package reset_seq_pkg;
  typedef enum logic [2:0] {S_ADC, S_DSP, S_CORE, S_RUN, S_DONE, S_FAIL} state_t;
  localparam int DEF_CNT_W = 64;
  function automatic int delay_w(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/reset_sequencer_run_watchdog.sv
// run_watchdog: saturating RUN-cycle counter plus timeout compare when RESET_SEQ_WATCHDOG_EN is defined.
import reset_seq_pkg::*;
module run_watchdog #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] max_cycles,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);
  always_ff @(posedge clock)
    if (reset || clear) count <= '0;
    else if (enable && !(&count)) count <= count + 1'b1;
`ifdef RESET_SEQ_WATCHDOG_EN
  assign timeout = (max_cycles != '0) && (count >= max_cycles);
`else
  logic unused_max;
  assign unused_max = ^max_cycles;
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered ADC -> DSP -> core reset release, then run monitoring with sticky done/failed.
// Timeout to S_FAIL exists only when RESET_SEQ_WATCHDOG_EN is defined.
import reset_seq_pkg::*;
module reset_sequencer #(
  parameter int ADC_DELAY  = 4,
  parameter int DSP_DELAY  = 8,
  parameter int CORE_DELAY = 8,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset_req,
  input  logic             success,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             adc_reset,
  output logic             dsp_reset,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             failed,
  output logic [CNT_W-1:0] cycle_count
);
  if (ADC_DELAY < 1 || DSP_DELAY < 1 || CORE_DELAY < 1) begin : g_bad_delay
    $error("reset_sequencer: delay parameters must be >= 1");
  end
  localparam int DW = delay_w(ADC_DELAY, DSP_DELAY, CORE_DELAY);
  localparam logic [DW-1:0] ADC_LAST  = DW'(ADC_DELAY - 1);
  localparam logic [DW-1:0] DSP_LAST  = DW'(DSP_DELAY - 1);
  localparam logic [DW-1:0] CORE_LAST = DW'(CORE_DELAY - 1);
  state_t state;
  logic [DW-1:0] cnt;
  logic timeout;
  logic enter_run;
  assign enter_run = (state == S_CORE) && (cnt == CORE_LAST);
  run_watchdog #(.CNT_W(CNT_W)) u_wd (
    .clock(clock),
    .reset(reset),
    .clear(soft_reset_req || enter_run),
    .enable((state == S_RUN) && !success && !timeout),
    .max_cycles(max_cycles),
    .count(cycle_count),
    .timeout(timeout)
  );
  always_ff @(posedge clock)
    if (reset || soft_reset_req) begin
      state <= S_ADC;
      cnt <= '0;
      adc_reset <= 1'b1;
      dsp_reset <= 1'b1;
      core_reset <= 1'b1;
      running <= 1'b0;
      done <= 1'b0;
      failed <= 1'b0;
    end else begin
      case (state)
        S_ADC:
          if (cnt == ADC_LAST) begin
            state <= S_DSP;
            cnt <= '0;
            adc_reset <= 1'b0;
          end else cnt <= cnt + 1'b1;
        S_DSP:
          if (cnt == DSP_LAST) begin
            state <= S_CORE;
            cnt <= '0;
            dsp_reset <= 1'b0;
          end else cnt <= cnt + 1'b1;
        S_CORE:
          if (enter_run) begin
            state <= S_RUN;
            cnt <= '0;
            core_reset <= 1'b0;
            running <= 1'b1;
          end else cnt <= cnt + 1'b1;
        S_RUN:
          if (success) begin
            state <= S_DONE;
            done <= 1'b1;
            running <= 1'b0;
          end else if (timeout) begin
            state <= S_FAIL;
            failed <= 1'b1;
            running <= 1'b0;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard of expected output transitions, checked by a negedge monitor.
module tb_reset_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic soft_reset_req = 1'b0;
  logic success = 1'b0;
  logic [63:0] max_cycles = '0;
  logic adc_reset, dsp_reset, core_reset, running, done, failed;
  logic [63:0] cycle_count;
  int checks = 0;
  int errors = 0;
  int e = 0;
  typedef struct {
    int ed;
    logic [5:0] vec;
    logic [63:0] cnt;
  } exp_t;
  exp_t q[$];
  logic [5:0] vec, pvec;
  logic [63:0] pcnt;
  int n_ev = 0;

  reset_sequencer dut (
    .clock(clock),
    .reset(reset),
    .soft_reset_req(soft_reset_req),
    .success(success),
    .max_cycles(max_cycles),
    .adc_reset(adc_reset),
    .dsp_reset(dsp_reset),
    .core_reset(core_reset),
    .running(running),
    .done(done),
    .failed(failed),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // edge index relative to the most recent reset or soft-reset edge
  always @(posedge clock) e <= (reset || soft_reset_req) ? 0 : e + 1;

  initial begin
    pvec = 'x;
    pcnt = 'x;
  end

  always @(negedge clock) begin
    exp_t x;
    checks++;
    if (!((adc_reset <= dsp_reset) && (dsp_reset <= core_reset))) begin
      errors++;
      $display("FAIL invariant: got adc=%b dsp=%b core=%b at edge %0d, need adc<=dsp<=core", adc_reset, dsp_reset, core_reset, e);
    end
    vec = {adc_reset, dsp_reset, core_reset, running, done, failed};
    if (vec !== pvec || cycle_count !== pcnt) begin
      checks++;
      n_ev++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change#%0d: got edge=%0d out=%b count=%0d, nothing expected", n_ev, e, vec, cycle_count);
      end else begin
        x = q.pop_front();
        if (x.ed != e || vec !== x.vec || cycle_count !== x.cnt) begin
          errors++;
          $display("FAIL transition#%0d: got edge=%0d out=%b count=%0d, want edge=%0d out=%b count=%0d", n_ev, e, vec, cycle_count, x.ed, x.vec, x.cnt);
        end
      end
    end
    pvec = vec;
    pcnt = cycle_count;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(int ed, logic [5:0] v, logic [63:0] c);
    q.push_back(exp_t'{ed, v, c});
  endtask

  task automatic push_bringup();
    push(0, 6'b111000, 0);
    push(4, 6'b011000, 0);
    push(12, 6'b001000, 0);
    push(20, 6'b000100, 0);
  endtask

  task automatic push_run(int from, int to);
    for (int k = from; k <= to; k++) push(20 + k, 6'b000100, 64'(k));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic drain(string name);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d expected transitions still pending, want 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    // long idle run: ordered release, no done/failed, count keeps climbing
    push_bringup();
    push_run(1, 1010);
    do_reset();
    tick(1030);
    drain("idle_run");
    // success after edge 22, then toggling success has no effect
    push_bringup();
    push_run(1, 2);
    push(23, 6'b000010, 2);
    do_reset();
    tick(22);
    success = 1'b1;
    tick(1);
    success = 1'b0;
    tick(2);
    success = 1'b1;
    tick(2);
    success = 1'b0;
    drain("done_sticky");
    // soft reset from DONE; success held high is ignored until RUN
    push_bringup();
    push(21, 6'b000010, 0);
    success = 1'b1;
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tick(22);
    success = 1'b0;
    drain("soft_from_done");
    // watchdog limit 5
    max_cycles = 64'd5;
    push_bringup();
`ifdef RESET_SEQ_WATCHDOG_EN
    push_run(1, 5);
    push(26, 6'b000001, 5);
`else
    push_run(1, 10);
`endif
    do_reset();
    tick(30);
    drain("watchdog_5");
    // success and timeout on the same edge: success wins
    max_cycles = 64'd2;
    push_bringup();
    push_run(1, 2);
    push(23, 6'b000010, 2);
    do_reset();
    tick(22);
    success = 1'b1;
    tick(2);
    success = 1'b0;
    max_cycles = '0;
    drain("success_beats_timeout");
    // limit lowered mid-run takes effect on the next edge
    push_bringup();
`ifdef RESET_SEQ_WATCHDOG_EN
    push_run(1, 5);
    push(26, 6'b000001, 5);
`else
    push_run(1, 6);
`endif
    do_reset();
    tick(25);
    max_cycles = 64'd3;
    tick(1);
    max_cycles = '0;
    drain("live_max_cycles");
    // soft reset in S_DSP at edge 7, then global reset mid-RUN
    push(0, 6'b111000, 0);
    push(4, 6'b011000, 0);
    push_bringup();
    push_run(1, 2);
    push_bringup();
    push_run(1, 1);
    do_reset();
    tick(6);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tick(22);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(21);
    drain("soft_dsp_and_reset_run");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
